// File: rtl/boolean_sweep_pkg.sv
// rtl/boolean_sweep_pkg.sv - shared state type and MISR constants for the boolean sweep checker
package boolean_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the feedback polynomial on a carried-out bit, mix in data.
  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic [15:0] din);
    return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/sweep_misr16.sv
// rtl/sweep_misr16.sv - 16-bit multiple-input signature register compressing sampled DUT responses
module sweep_misr16
  import boolean_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  // Signature register: reseeded on clear, advanced once per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/boolean_sweep_checker.sv
// rtl/boolean_sweep_checker.sv - exhaustive truth-table sweep checker for a combinational block; optional MISR via BOOLEAN_SWEEP_MISR_EN
module boolean_sweep_checker
  import boolean_sweep_pkg::*;
#(
  parameter int                         N_IN   = 4,
  parameter int                         N_OUT  = 2,
  parameter int                         SETTLE = 1,
  parameter logic [(N_OUT<<N_IN)-1:0]   EXP_TT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_idx
`ifdef BOOLEAN_SWEEP_MISR_EN
  ,
  output logic [15:0]       sig
`endif
);

  localparam int              N_VEC     = 1 << N_IN;
  localparam logic [3:0]      HOLD_LOAD = 4'(SETTLE);
  localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);

  state_t            state;
  state_t            state_nx;
  logic [N_IN-1:0]   idx;
  logic [3:0]        hold;

  logic              start_sweep;
  logic              sample;
  logic              hold_dec;
  logic              abort_run;
  logic              last_vec;
  logic              mismatch;

  // Truth table unpacked into one row per input vector.
  logic [N_OUT-1:0]  tt_row [N_VEC];

  for (genvar g = 0; g < N_VEC; g++) begin : g_tt
    assign tt_row[g] = EXP_TT[g*N_OUT +: N_OUT];
  end

  assign last_vec = &idx;

  // Case-inequality so an X or Z response is never mistaken for a match.
  assign mismatch = (dut_out !== tt_row[idx]);

  assign dut_in = (state == RUN) ? idx : '0;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-cycle control strobes; abort beats a same-cycle sample.
  always_comb begin
    state_nx    = state;
    start_sweep = 1'b0;
    sample      = 1'b0;
    hold_dec    = 1'b0;
    abort_run   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = RUN;
          start_sweep = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx  = IDLE;
          abort_run = 1'b1;
        end else if (hold == 4'd0) begin
          sample = 1'b1;
          if (last_vec) begin
            state_nx = DONE;
          end
        end else begin
          hold_dec = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Vector index, hold counter and result registers; results persist in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      hold            <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      pass            <= 1'b0;
    end else if (start_sweep) begin
      idx             <= '0;
      hold            <= HOLD_LOAD;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        err_cnt <= err_cnt + ERR_ONE;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= idx;
        end
      end
      if (last_vec) begin
        // pass must include the final vector's outcome, so it is resolved here, not from err_cnt later
        pass <= (err_cnt == '0) && !mismatch;
      end else begin
        idx  <= idx + IDX_ONE;
        hold <= HOLD_LOAD;
      end
    end else if (hold_dec) begin
      hold <= hold - 4'd1;
    end else if (abort_run) begin
      pass <= 1'b0;
    end
  end

`ifdef BOOLEAN_SWEEP_MISR_EN
  logic [15:0] misr_din;

  // Zero-extend the response to the MISR width.
  always_comb begin
    misr_din              = '0;
    misr_din[N_OUT-1:0]   = dut_out;
  end

  sweep_misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_sweep),
    .en    (sample),
    .din   (misr_din),
    .sig   (sig)
  );
`endif

endmodule

// File: tb/tb_boolean_sweep_checker.sv
// tb/tb_boolean_sweep_checker.sv - scoreboard bench for boolean_sweep_checker
`timescale 1ns/1ps
module tb_boolean_sweep_checker;

  localparam int N_VEC = 16;
  localparam int HOLD  = 2;

  // Reference block: out[1] = a&b | c&~d, out[0] = a^b^c^d, with a = MSB of the vector.
  function automatic logic [1:0] ref_out(input int v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    ref_out[1] = (a & b) | (c & ~d);
    ref_out[0] = a ^ b ^ c ^ d;
  endfunction

  function automatic logic [31:0] build_tt();
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < N_VEC; i++) t[i*2 +: 2] = ref_out(i);
    return t;
  endfunction

  localparam logic [31:0] TT = build_tt();

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [15:0] d);
    logic [16:0] w;
    w = {1'b0, s} * 2;
    return w[15:0] ^ (w[16] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  typedef struct {
    int          err;
    bit          fev;
    int          fei;
    bit          pass;
    int          done_cyc;
    logic [15:0] sig;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  dut_in;
  logic [1:0]  dut_out;
  logic        busy, done, pass, fev;
  logic [4:0]  err_cnt;
  logic [3:0]  fei;
  logic [15:0] bad_mask = '0;

  logic        start2 = 1'b0;
  logic [3:0]  dut_in2;
  logic        busy2, done2, pass2, fev2;
  logic [4:0]  err2;
  logic [3:0]  fei2;
`ifdef BOOLEAN_SWEEP_MISR_EN
  logic [15:0] sig, sig2;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Modelled DUT: reference function with bit0 flipped on vectors flagged in bad_mask.
  assign dut_out = ref_out(int'(dut_in)) ^ {1'b0, bad_mask[dut_in]};

  boolean_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(1), .EXP_TT(TT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_valid(fev), .first_err_idx(fei)
`ifdef BOOLEAN_SWEEP_MISR_EN
    , .sig(sig)
`endif
  );

  boolean_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(0), .EXP_TT(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .dut_in(dut_in2), .dut_out(2'b00), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_err_valid(fev2), .first_err_idx(fei2)
`ifdef BOOLEAN_SWEEP_MISR_EN
    , .sig(sig2)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model_sweep(input logic [15:0] mask, input int t0c);
    exp_t e;
    e.err  = $countones(mask);
    e.fev  = (mask != 16'h0);
    e.fei  = 0;
    for (int i = N_VEC - 1; i >= 0; i--) if (mask[i]) e.fei = i;
    e.pass = (mask == 16'h0);
    e.done_cyc = t0c + N_VEC * HOLD;
    e.sig = 16'hFFFF;
    for (int v = 0; v < N_VEC; v++) e.sig = misr_model(e.sig, 16'(ref_out(v) ^ {1'b0, mask[v]}));
    return e;
  endfunction

  // Monitor: vector sequence while busy, and scoreboard pop on every done pulse.
  int run_cycles = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (busy) begin
        check("dut_in_seq", int'(dut_in), run_cycles / HOLD);
        run_cycles++;
      end else begin
        run_cycles = 0;
      end
      if (done) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("err_cnt", int'(err_cnt), e.err);
          check("first_err_valid", int'(fev), int'(e.fev));
          if (e.fev) check("first_err_idx", int'(fei), e.fei);
          check("pass", int'(pass), int'(e.pass));
          check("done_dut_in", int'(dut_in), 0);
`ifdef BOOLEAN_SWEEP_MISR_EN
          check("sig", int'(sig), int'(e.sig));
`endif
        end
      end
    end
  end

  int t0c, n, extra, saved_err;

  task automatic begin_sweep(input bit expect_done);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0c = cyc;
    check("start_busy", int'(busy), 1);
    if (expect_done) sb.push_back(model_sweep(bad_mask, t0c));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    check("done_seen", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic wait_vec(input int v, input int budget);
    int k = 0;
    while (!(busy && int'(dut_in) == v) && k < budget) begin @(negedge clk); k++; end
    check("reach_vector", int'(dut_in), v);
  endtask

  function automatic logic [15:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h0001 << $urandom_range(0, 15);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_cnt), 0);
    check({tag, "_fev"}, int'(fev), 0);
    check({tag, "_fei"}, int'(fei), 0);
    check({tag, "_dut_in"}, int'(dut_in), 0);
`ifdef BOOLEAN_SWEEP_MISR_EN
    check({tag, "_sig"}, int'(sig), 16'hFFFF);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check("reset2_busy", int'(busy2), 0);
    check("reset2_dut_in", int'(dut_in2), 0);
    check("reset2_fei", int'(fei2), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean sweep, then vectors 5 and 11 corrupted.
    bad_mask = 16'h0000; begin_sweep(1'b1); wait_done(100);
    bad_mask = 16'h0820; begin_sweep(1'b1); wait_done(100);

    // Randomised fault patterns with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      bad_mask = rand_mask();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      begin_sweep(1'b1);
      wait_done(100);
    end

    // Abort while vector 7 is driven; randomly lands on the sample edge of vector 7.
    bad_mask = 16'($urandom) | 16'h0001;
    begin_sweep(1'b0);
    wait_vec(7, 100);
    extra = $urandom_range(0, 1);
    repeat (extra) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_dut_in", int'(dut_in), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_err", int'(err_cnt), $countones(bad_mask & 16'h007F));
    check("abort_fei", int'(fei), 0);
    saved_err = int'(err_cnt);
    abort = 1'b1;
    repeat (40) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    check("idle_hold_err", int'(err_cnt), saved_err);

    // Start pulse during RUN ignored; start held through DONE re-triggers from IDLE.
    bad_mask = rand_mask();
    begin_sweep(1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = t0c;
    while (cyc < n + 30) @(negedge clk);
    start = 1'b1;
    while (cyc < n + 33) @(negedge clk);
    check("retrig_idle", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("retrig_busy", int'(busy), 1);
    sb.push_back(model_sweep(bad_mask, cyc));
    wait_done(100);

    // Asynchronous reset while vector 9 is driven, then a full sweep.
    bad_mask = rand_mask();
    begin_sweep(1'b1);
    wait_vec(9, 100);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bad_mask = rand_mask();
    begin_sweep(1'b1);
    wait_done(100);

    // SETTLE=0 instance with constant zero response.
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    t0c = cyc;
    n = 0;
    while (!done2 && n < 60) begin @(negedge clk); n++; end
    check("s0_done_cycle", cyc - t0c, N_VEC);
    check("s0_pass", int'(pass2), 1);
    check("s0_err", int'(err2), 0);
    check("s0_fev", int'(fev2), 0);
    check("s0_dut_in", int'(dut_in2), 0);
`ifdef BOOLEAN_SWEEP_MISR_EN
    begin
      logic [15:0] s;
      s = 16'hFFFF;
      for (int i = 0; i < N_VEC; i++) s = misr_model(s, 16'h0000);
      check("s0_sig", int'(sig2), int'(s));
    end
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
